// File: rtl/code_deconcatenator.sv
// Prefix-code stream decoder: rebuilds 32-bit words from a packed MSB-first bitstream
// using a 16-entry FIFO dictionary. Optional macro DICT_VALID_CHECK_EN adds per-entry valid bits.
module code_deconcatenator #(
  parameter int DATA_WIDTH = 32,
  parameter int TOTAL_BITS = 34,
  parameter int DICT_DEPTH = 16,
  parameter int IN_WIDTH   = 32,
  parameter int BUF_WIDTH  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [15:0]           i_word_count,
  input  logic                  i_in_valid,
  input  logic [IN_WIDTH-1:0]   i_in_data,
  output logic                  o_in_ready,
  output logic                  o_out_valid,
  output logic [DATA_WIDTH-1:0] o_out_word,
  input  logic                  i_out_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int CW = $clog2(BUF_WIDTH + 1);
  localparam int IW = $clog2(DICT_DEPTH);

  typedef enum logic [1:0] {IDLE, DECODE, DONE, ERROR} state_t;

  state_t                state, state_nxt;
  logic [BUF_WIDTH-1:0]  bit_buf, buf_nxt;
  logic [CW-1:0]         bit_cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] dict [DICT_DEPTH];
  logic [IW-1:0]         wp;
  logic [15:0]           remaining;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_word;

  logic [CW-1:0]         code_len, consumed;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] dec_word;
  logic                  push, uses_dict, illegal, bad;
  logic                  enough, attempt, fire, go_err, in_ready, accept;

  // Code selection from the head of the MSB-aligned buffer.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    code_len  = CW'(2);
    dec_word  = '0;
    push      = 1'b0;
    uses_dict = 1'b0;
    illegal   = 1'b0;
    idx       = bit_buf[BUF_WIDTH-3 -: IW];
    unique case (bit_buf[BUF_WIDTH-1 -: 2])
      2'b00: ;
      2'b01: begin
        code_len = CW'(TOTAL_BITS);
        dec_word = bit_buf[BUF_WIDTH-3 -: DATA_WIDTH];
        push     = 1'b1;
      end
      2'b10: begin
        code_len  = CW'(6);
        dec_word  = dict[idx];
        uses_dict = 1'b1;
      end
      default: begin
        idx = bit_buf[BUF_WIDTH-5 -: IW];
        unique case (bit_buf[BUF_WIDTH-3 -: 2])
          2'b00: begin
            code_len  = CW'(24);
            dec_word  = {dict[idx][DATA_WIDTH-1:16], bit_buf[BUF_WIDTH-9 -: 16]};
            push      = 1'b1;
            uses_dict = 1'b1;
          end
          2'b01: begin
            code_len = CW'(12);
            dec_word = {{(DATA_WIDTH-8){1'b0}}, bit_buf[BUF_WIDTH-5 -: 8]};
          end
          2'b10: begin
            code_len  = CW'(16);
            dec_word  = {dict[idx][DATA_WIDTH-1:8], bit_buf[BUF_WIDTH-9 -: 8]};
            push      = 1'b1;
            uses_dict = 1'b1;
          end
          default: begin
            code_len = CW'(4);
            illegal  = 1'b1;
          end
        endcase
      end
    endcase
  end

`ifdef DICT_VALID_CHECK_EN
  logic [DICT_DEPTH-1:0] dict_vld;
  assign bad = illegal || (uses_dict && !dict_vld[idx]);
`else
  assign bad = illegal;
`endif

  assign enough = (bit_cnt >= CW'(2))
               && (bit_buf[BUF_WIDTH-1 -: 2] != 2'b11 || bit_cnt >= CW'(4))
               && (bit_cnt >= code_len);
  assign attempt  = (state == DECODE) && (remaining != 16'd0) && enough
                 && (!out_valid || i_out_ready);
  assign fire     = attempt && !bad;
  assign go_err   = attempt && bad;
  assign in_ready = (state == DECODE) && (bit_cnt <= CW'(BUF_WIDTH - IN_WIDTH));
  assign accept   = i_in_valid && in_ready;
  assign consumed = fire ? code_len : '0;

  // The incoming word lands directly below the bits that survive this cycle's shift.
  always_comb begin
    buf_nxt = bit_buf << consumed;
    cnt_nxt = bit_cnt - consumed;
    if (accept) begin
      buf_nxt = buf_nxt
              | ({i_in_data, {(BUF_WIDTH-IN_WIDTH){1'b0}}} >> (bit_cnt - consumed));
      cnt_nxt = cnt_nxt + CW'(IN_WIDTH);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      DECODE: begin
        if (go_err)
          state_nxt = ERROR;
        else if (remaining == 16'd0 && out_valid && i_out_ready)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: ;
    endcase
    if (i_start)
      state_nxt = (i_word_count == 16'd0) ? DONE : DECODE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the dictionary is reset explicitly because an unwritten entry must read as zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      bit_buf   <= '0;
      bit_cnt   <= '0;
      wp        <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      for (int i = 0; i < DICT_DEPTH; i++) dict[i] <= '0;
    end else if (i_start) begin
      state     <= state_nxt;
      bit_buf   <= '0;
      bit_cnt   <= '0;
      wp        <= '0;
      remaining <= i_word_count;
      out_valid <= 1'b0;
      out_word  <= '0;
      for (int i = 0; i < DICT_DEPTH; i++) dict[i] <= '0;
    end else begin
      state   <= state_nxt;
      bit_buf <= buf_nxt;
      bit_cnt <= cnt_nxt;
      if (fire) begin
        out_valid <= 1'b1;
        out_word  <= dec_word;
        remaining <= remaining - 16'd1;
        if (push) begin
          dict[wp] <= dec_word;
          wp       <= (wp == IW'(DICT_DEPTH - 1)) ? '0 : wp + IW'(1);
        end
      end else if (i_out_ready || go_err) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DICT_VALID_CHECK_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      dict_vld <= '0;
    else if (i_start)
      dict_vld <= '0;
    else if (fire && push)
      dict_vld[wp] <= 1'b1;
  end
`endif

  assign o_in_ready  = in_ready;
  assign o_out_valid = out_valid;
  assign o_out_word  = out_word;
  assign o_busy      = (state == DECODE);
  assign o_done      = (state == DONE);
  assign o_error     = (state == ERROR);

endmodule

// File: tb/tb_code_deconcatenator.sv
// Directed, table-driven bench for code_deconcatenator: each block is a list of
// {code bits, code length, expected word} records packed into a stream and checked in order.
module tb_code_deconcatenator;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_in_valid, i_out_ready;
  logic [15:0] i_word_count;
  logic [31:0] i_in_data;
  logic        o_in_ready, o_out_valid, o_busy, o_done, o_error;
  logic [31:0] o_out_word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  code_deconcatenator dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_word_count(i_word_count),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_out_valid(o_out_valid), .o_out_word(o_out_word), .i_out_ready(i_out_ready),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  typedef struct {
    logic [33:0] bits;
    int          len;
    logic [31:0] exp;
  } vec_t;

  vec_t        blk[$];
  logic [31:0] words[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t v_zero();
    return '{bits: 34'd0, len: 2, exp: 32'h0};
  endfunction
  function automatic vec_t v_lit(input logic [31:0] w);
    return '{bits: {2'b01, w}, len: 34, exp: w};
  endfunction
  function automatic vec_t v_dict(input logic [3:0] idx, input logic [31:0] e);
    return '{bits: {28'd0, 2'b10, idx}, len: 6, exp: e};
  endfunction
  function automatic vec_t v_hi(input logic [3:0] idx, input logic [15:0] lo, input logic [31:0] e);
    return '{bits: {10'd0, 4'b1100, idx, lo}, len: 24, exp: e};
  endfunction
  function automatic vec_t v_byte(input logic [7:0] b);
    return '{bits: {22'd0, 4'b1101, b}, len: 12, exp: {24'd0, b}};
  endfunction
  function automatic vec_t v_mid(input logic [3:0] idx, input logic [7:0] b, input logic [31:0] e);
    return '{bits: {18'd0, 4'b1110, idx, b}, len: 16, exp: e};
  endfunction

  task automatic build_words();
    bit          sbits[$];
    logic [31:0] w;
    words.delete();
    foreach (blk[i])
      for (int b = blk[i].len - 1; b >= 0; b--) sbits.push_back(blk[i].bits[b]);
    while (sbits.size() % 32 != 0) sbits.push_back(1'b0);
    for (int k = 0; k < sbits.size(); k += 32) begin
      w = '0;
      for (int j = 0; j < 32; j++) w = {w[30:0], sbits[k+j]};
      words.push_back(w);
    end
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    i_start      = 1'b1;
    i_word_count = 16'(n);
    @(negedge clk);
    i_start      = 1'b0;
  endtask

  // Streams the current table through the DUT; stall = output stall cycles to insert.
  task automatic run_block(input string tag, input int stall);
    int          k = 0, wi = 0, stalls = 0;
    bit          done_seen = 0, prev_stall = 0, saw_low = 0, rdy;
    logic [31:0] prev_word = '0;
    build_words();
    pulse_start(blk.size());
    check({tag, "_error_clear"}, o_error, 0);
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      if (o_done) begin
        done_seen = 1;
      end else begin
        if (prev_stall) begin
          check({tag, "_hold_valid"}, o_out_valid, 1);
          check({tag, "_hold_word"}, o_out_word, prev_word);
        end
        rdy = !(o_out_valid && stalls < stall);
        if (!rdy) stalls++;
        i_out_ready = rdy;
        i_in_valid  = (wi < words.size());
        i_in_data   = (wi < words.size()) ? words[wi] : 32'h0;
        if (o_busy && !o_in_ready) saw_low = 1;
        if (i_in_valid && o_in_ready) wi++;
        if (o_out_valid && rdy) begin
          if (k < blk.size()) check($sformatf("%s_word%0d", tag, k), o_out_word, blk[k].exp);
          else                check({tag, "_extra_word"}, 1, 0);
          k++;
        end
        prev_stall = o_out_valid && !rdy;
        prev_word  = o_out_word;
        @(negedge clk);
      end
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    check({tag, "_done_seen"}, done_seen, 1);
    check({tag, "_word_total"}, k, blk.size());
    check({tag, "_valid_in_done"}, o_out_valid, 0);
    if (stall > 0) check({tag, "_in_ready_dropped"}, saw_low, 1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, o_done, 0);
    check({tag, "_idle_after"}, o_busy, 0);
  endtask

  task automatic load_all_codes();
    blk.delete();
    blk.push_back(v_zero());
    blk.push_back(v_lit(32'hDEADBEEF));
    blk.push_back(v_dict(4'd0, 32'hDEADBEEF));
  endtask

  initial begin
    bit got_valid;
    i_rst = 1'b1; i_start = 1'b0; i_word_count = '0;
    i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_out_word", o_out_word, 0);
    check("rst_in_ready", o_in_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_error", o_error, 0);
    i_rst = 1'b0;

    // All three basic code types.
    load_all_codes();
    build_words();
    check("pack_w0", words[0], 32'h1DEADBEE);
    check("pack_w1", words[1], 32'hF8000000);
    run_block("allcodes", 0);

    // Same block with a 5-cycle output stall.
    load_all_codes();
    run_block("bp", 5);

    // Partial-match codes against a seeded dictionary.
    blk.delete();
    blk.push_back(v_lit(32'h12345678));
    blk.push_back(v_mid(4'd0, 8'h9A, 32'h1234569A));
    blk.push_back(v_hi(4'd1, 16'hBEEF, 32'h1234BEEF));
    blk.push_back(v_byte(8'h7F));
    blk.push_back(v_dict(4'd1, 32'h1234569A));
    blk.push_back(v_dict(4'd2, 32'h1234BEEF));
    run_block("partial", 0);

    // Illegal 1111 prefix.
    pulse_start(2);
    i_in_valid = 1'b1;
    i_in_data  = 32'hF0000000;
    check("ill_in_ready", o_in_ready, 1);
    @(negedge clk);
    i_in_valid = 1'b0;
    got_valid  = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_out_valid) got_valid = 1;
      @(negedge clk);
    end
    check("ill_no_output", got_valid, 0);
    check("ill_error", o_error, 1);
    check("ill_in_ready_low", o_in_ready, 0);
    check("ill_out_valid", o_out_valid, 0);
    check("ill_not_busy", o_busy, 0);
    load_all_codes();
    run_block("resume", 0);

    // Dictionary write pointer wrap.
    blk.delete();
    for (int i = 1; i <= 17; i++) blk.push_back(v_lit(32'(i)));
    blk.push_back(v_dict(4'd0, 32'd17));
    blk.push_back(v_dict(4'd1, 32'd2));
    run_block("wrap", 0);

    // Zero-length block.
    pulse_start(0);
    check("wc0_done", o_done, 1);
    check("wc0_valid", o_out_valid, 0);
    check("wc0_busy", o_busy, 0);
    @(negedge clk);
    check("wc0_done_once", o_done, 0);

    // Reset in the middle of a block.
    load_all_codes();
    build_words();
    pulse_start(blk.size());
    i_out_ready = 1'b0;
    got_valid   = 0;
    for (int c = 0, wi = 0; c < 20 && !got_valid; c++) begin
      if (o_out_valid) begin
        got_valid = 1;
      end else begin
        i_in_valid = (wi < words.size());
        i_in_data  = (wi < words.size()) ? words[wi] : 32'h0;
        if (i_in_valid && o_in_ready) wi++;
        @(negedge clk);
      end
    end
    i_in_valid = 1'b0;
    check("mid_valid_before_rst", got_valid, 1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", o_out_valid, 0);
    check("mid_rst_word", o_out_word, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_in_ready", o_in_ready, 0);
    check("mid_rst_done", o_done, 0);
    check("mid_rst_error", o_error, 0);
    @(negedge clk);
    i_rst = 1'b0;
    i_out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_rst_no_done", o_done, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
